// File: rtl/cpu_bus_store_responder.sv
// rtl/cpu_bus_store_responder.sv - cpu6502 bus RAM responder with store log (option: CPU_BUS_STORE_RESPONDER_CLEAR_EN)
module cpu_bus_store_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int          LOG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  addr,
    input  logic [7:0]                   odata,
    input  logic                         rw,
    input  logic                         clk2,
    output logic [7:0]                   idata,
    output logic                         sel,
    output logic                         log_valid,
    input  logic                         log_ready,
    output logic [15:0]                  log_addr,
    output logic [7:0]                   log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         overflow,
    output logic                         busy
);
    localparam int              MEM_SIZE   = 1 << ADDR_BITS;
    localparam int              PW         = $clog2(LOG_DEPTH);
    localparam logic [PW:0]     FULL_COUNT = (PW+1)'(LOG_DEPTH);

    logic [7:0]           mem [MEM_SIZE];
    logic                 clk2_q;
    logic                 armed;
    logic                 p2_rise;
    logic                 hit;
    logic [ADDR_BITS-1:0] idx;
    logic                 store_en;
    logic                 clearing;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_wa;
    logic [7:0]           mem_wd;

    assign hit     = (addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]);
    assign idx     = addr[ADDR_BITS-1:0];
    assign p2_rise = clk2 & ~clk2_q;
    // armed blocks a store whose phi2 rise lands on the first edge out of reset
    assign store_en = p2_rise & ~rw & armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk2_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            clk2_q <= clk2;
            armed  <= 1'b1;
        end
    end

`ifdef CPU_BUS_STORE_RESPONDER_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    state_t               state, state_nx;
    logic [ADDR_BITS-1:0] clr_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR)
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == S_CLEAR && clr_ptr == {ADDR_BITS{1'b1}})
            state_nx = S_IDLE;
    end

    always_comb begin
        clearing = (state == S_CLEAR);
        mem_we   = 1'b0;
        mem_wa   = idx;
        mem_wd   = odata;
        if (clearing) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr;
            mem_wd = 8'h00;
        end else if (store_en && hit) begin
            mem_we = 1'b1;
        end
    end
`else
    always_comb begin
        clearing = 1'b0;
        mem_we   = store_en & hit;
        mem_wa   = idx;
        mem_wd   = odata;
    end
`endif

    assign busy = clearing;

    // RAM is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idata <= 8'hff;
            sel   <= 1'b0;
        end else begin
            sel <= hit;
            if (rw)
                idata <= !hit ? 8'hff : (clearing ? 8'h00 : mem[idx]);
        end
    end

    logic [15:0]   fifo_addr [LOG_DEPTH];
    logic [7:0]    fifo_data [LOG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign full      = (count == FULL_COUNT);
    assign log_valid = (count != '0);
    assign pop       = log_valid & log_ready;
    // a pop in the same clk frees the slot, so a full log still accepts the push
    assign push_ok   = store_en & (~full | pop);
    assign log_addr  = fifo_addr[rd_ptr];
    assign log_data  = fifo_data[rd_ptr];
    assign log_count = count;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= odata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (store_en && full && !pop)
                overflow <= 1'b1;
        end
    end
endmodule

// File: doc/cpu_bus_store_responder.md
Name: cpu_bus_store_responder

Overview:
- Memory-side responder for the cpu6502 external bus; the counterpart to the CPU's load/store initiator.
- Serves read data on idata from a small internal RAM window.
- Commits CPU stores into that RAM.
- Records every store, in or out of the window, into a FIFO log that benches and checkers drain through a valid/ready port.

Parameters:
- ADDR_BITS, 8: RAM size is 2^ADDR_BITS bytes.
- BASE, 16'h0000: first CPU address of the RAM window; must be aligned to 2^ADDR_BITS.
- LOG_DEPTH, 8: store-log entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; same clock that drives cpu6502.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- addr  in  16  CPU address bus.
- odata  in  8  CPU write data.
- rw  in  1  CPU direction; 1 = read, 0 = write.
- clk2  in  1  CPU phi2 output, sampled in the clk domain.
- idata  out  8  read data to CPU.
- sel  out  1  registered; addr falls inside [BASE, BASE+2^ADDR_BITS-1].
- log_valid  out  1  log head entry available.
- log_ready  in  1  consumer accepts head entry.
- log_addr  out  16  head entry address.
- log_data  out  8  head entry data.
- log_count  out  $clog2(LOG_DEPTH)+1  entries currently held.
- overflow  out  1  sticky; a store was dropped because the log was full.
- busy  out  1  clear sweep in progress (see Optional Feature).

Behaviour:
- Reset asserted: idata=8'hff, sel=0, log empty (log_valid=0, log_count=0), overflow=0, busy=0, clk2_q=0. RAM contents are not affected by reset.
- Phase detect: clk2_q <= clk2 every clk.
  - p2_rise = clk2 & ~clk2_q.
  - p2_fall = ~clk2 & clk2_q.
- Window hit: hit = (addr[15:ADDR_BITS] == BASE[15:ADDR_BITS]). Index = addr[ADDR_BITS-1:0].
- Read path, registered, 1 clk latency:
  - Every clk with rw=1: idata <= hit ? mem[index] : 8'hff.
  - With rw=0, idata holds its value.
  - Data must be stable before p2_fall, which is when the CPU samples loads.
- Store, on the clk edge where p2_rise & ~rw:
  - If hit, mem[index] <= odata.
  - Always push {addr, odata} into the log.
  - At most one store is accepted per phi2 high phase; rw=0 held across later clks of the same phase is ignored until the next p2_rise.
- Log FIFO:
  - Head is presented combinationally from storage; log_valid = (count != 0).
  - Pop occurs when log_valid & log_ready.
  - Push and pop in the same clk: both take effect and count is unchanged. This holds even when full, because the pop frees a slot.
  - Push when full with no pop: entry dropped, overflow <= 1, count stays LOG_DEPTH.
  - Pop when empty: ignored.
  - Pointers wrap modulo LOG_DEPTH.
- Reset asserted mid-phase: FIFO cleared immediately. A store whose p2_rise coincides with reset release is not captured.

Optional Feature:
- Macro: CPU_BUS_STORE_RESPONDER_CLEAR_EN.
- Defined: two-state FSM, CLEAR then IDLE.
  - On reset, the FSM enters CLEAR with sweep pointer = 0 and busy = 1.
  - Each clk in CLEAR: mem[ptr] <= 0, ptr increments.
  - After the 2^ADDR_BITS-th write, the FSM goes to IDLE and busy = 0.
  - During CLEAR: stores are still logged but not written to RAM; reads in the window return 8'h00.
  - Reset asserted during CLEAR restarts the sweep from 0.
- Undefined: no FSM; busy tied 0; RAM starts uninitialised; module starts in IDLE behaviour.

Test Plan:
- Store hit: with BASE=0, CPU runs LDA #$00 / STA $99 → at p2_rise, log entry {16'h0099, 8'h00} is pushed; mem[8'h99]=0; log_count=1.
- Read-back: preload mem[8'h10]=8'h5a via a store, then hold addr=16'h0010, rw=1 → idata=8'h5a one clk later, sel=1. Then addr=16'h1234 → idata=8'hff, sel=0.
- Out-of-window store: store 8'h77 to 16'h4000 → log entry {16'h4000, 8'h77}; no RAM location changes.
- Overflow: log_ready=0, 9 stores with LOG_DEPTH=8 → log_count=8, overflow=1, head is still the first store. Then log_ready=1 for 8 clks → entries drain in order, log_valid=0, overflow stays 1.
- Simultaneous push and pop when full: count stays 8, head advances by one, overflow unchanged.
- CLEAR_EN defined: reset released → busy high for exactly 256 clks (ADDR_BITS=8), then every window read returns 8'h00. Reset pulsed at sweep clk 100 → busy high for a further 256 clks after release.
